// File: rtl/mips_pkg.sv
// Shared opcode/funct/ALU constants, state encoding and opcode classification.
// Purely declarative; no latency.
// No flow control.
package mips_pkg;

   // Opcodes from IR[31:26]
   localparam logic [5:0] OP_R     = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDIU = 6'b001001;

   // R-type funct codes from IR[5:0]
   localparam logic [5:0] FN_ADD  = 6'b100000;
   localparam logic [5:0] FN_ADDU = 6'b100001;
   localparam logic [5:0] FN_SUB  = 6'b100010;
   localparam logic [5:0] FN_SUBU = 6'b100011;
   localparam logic [5:0] FN_AND  = 6'b100100;
   localparam logic [5:0] FN_OR   = 6'b100101;
   localparam logic [5:0] FN_SLT  = 6'b101010;

   // ALU operation codes
   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;

   // PC source select
   localparam logic [1:0] PC_SRC_INC = 2'd0;
   localparam logic [1:0] PC_SRC_BR  = 2'd1;
   localparam logic [1:0] PC_SRC_JMP = 2'd2;

   typedef enum logic [2:0] {ST_IF, ST_ID, ST_EX, ST_MEM, ST_WB} state_t;

   typedef enum logic [2:0] {CLS_R, CLS_LW, CLS_SW, CLS_ADDIU, CLS_BEQ, CLS_J, CLS_ILL} op_cls_t;

   // Collapse the raw opcode into the instruction class the sequencer cares about
   function automatic op_cls_t op_class(input logic [5:0] op);
      op_cls_t cls;
      case (op)
         OP_R:     cls = CLS_R;
         OP_LW:    cls = CLS_LW;
         OP_SW:    cls = CLS_SW;
         OP_ADDIU: cls = CLS_ADDIU;
         OP_BEQ:   cls = CLS_BEQ;
         OP_J:     cls = CLS_J;
         default:  cls = CLS_ILL;
      endcase
      return cls;
   endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Shared instruction/data memory port between sequencer and memory.
// Request held until the cycle the memory acks it.
// Memory stalls the sequencer simply by withholding mem_ack.
interface multicycle_ctrl_if;
   logic mem_req;
   logic mem_ren;
   logic mem_wen;
   logic mem_iord;
   logic mem_ack;

   modport master (output mem_req, output mem_ren, output mem_wen, output mem_iord, input mem_ack);
   modport slave  (input mem_req, input mem_ren, input mem_wen, input mem_iord, output mem_ack);
endinterface

// File: rtl/multicycle_ctrl_alu_dec.sv
// Maps instruction class + funct to an ALU op code and a legality flag.
// Combinational, zero latency.
// No flow control.
module alu_dec
   import mips_pkg::*;
(
   input  op_cls_t    i_cls,
   input  logic [5:0] i_funct,
   output logic [3:0] o_alu,
   output logic       o_legal
);

   // Address arithmetic adds, beq compares by subtraction, R-type follows funct
   always_comb begin
      o_alu   = ALU_ADD;
      o_legal = 1'b1;
      case (i_cls)
         CLS_BEQ: o_alu = ALU_SUB;
         CLS_ILL: o_legal = 1'b0;
         CLS_R: begin
            case (i_funct)
               FN_ADD, FN_ADDU: o_alu = ALU_ADD;
               FN_SUB, FN_SUBU: o_alu = ALU_SUB;
               FN_AND:          o_alu = ALU_AND;
               FN_OR:           o_alu = ALU_OR;
               FN_SLT:          o_alu = ALU_SLT;
               default:         o_legal = 1'b0;
            endcase
         end
         default: o_alu = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle IF/ID/EX/MEM/WB sequencer driving datapath enables for the MIPS subset.
// Latency (zero-wait memory): j=2, beq=3, R/addiu/sw=4, lw=5 cycles.
// Stalls in IF/MEM until mem_ack; abandons the access after TIMEOUT wait cycles.
module multicycle_ctrl
   import mips_pkg::*;
#(
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [5:0]        ct_inst,
   input  logic [5:0]        aluct_inst,
   input  logic              alu_zero,
   multicycle_ctrl_if.master mem,
   output logic              ir_wen,
   output logic              pc_wen,
   output logic [1:0]        pc_src,
   output logic              ct_rf_wen,
   output logic              ct_rf_dst,
   output logic              ct_data_rf,
   output logic              ct_alu_src,
   output logic [3:0]        ct_alu,
   output logic              bus_err,
   output logic              ill_inst
);

   localparam int              CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] W_TO = CNT_W'(TIMEOUT);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_wait_cnt;
   logic [CNT_W-1:0] w_wait_nxt;
   logic             r_bus_err;

   op_cls_t          w_cls;
   logic [3:0]       w_alu_dec;
   logic             w_legal;
   logic             w_timed_out;
   logic             w_imm_op;

   logic             w_req, w_ren, w_wen, w_iord, w_ir_wen, w_pc_wen;
   logic [1:0]       w_pc_src;
   logic             w_rf_wen, w_rf_dst, w_data_rf, w_alu_src, w_ill;
   logic [3:0]       w_alu;

   assign w_cls       = op_class(ct_inst);
   assign w_timed_out = (r_wait_cnt == W_TO);
   assign w_imm_op    = (w_cls == CLS_LW) || (w_cls == CLS_SW) || (w_cls == CLS_ADDIU);

   alu_dec u_alu_dec (
      .i_cls   (w_cls),
      .i_funct (aluct_inst),
      .o_alu   (w_alu_dec),
      .o_legal (w_legal)
   );

   // State, wait counter and sticky bus error; bus_err rises on the edge the counter hits TIMEOUT
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= ST_IF;
         r_wait_cnt <= '0;
         r_bus_err  <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_wait_cnt <= w_wait_nxt;
         if (w_wait_nxt == W_TO) begin
            r_bus_err <= 1'b1;
         end
      end
   end

   // Next state and datapath controls; a timed-out cycle drops the request and returns to IF
   always_comb begin
      w_state_nxt = r_state;
      w_wait_nxt  = '0;
      w_req       = 1'b0;
      w_ren       = 1'b0;
      w_wen       = 1'b0;
      w_iord      = 1'b0;
      w_ir_wen    = 1'b0;
      w_pc_wen    = 1'b0;
      w_pc_src    = PC_SRC_INC;
      w_rf_wen    = 1'b0;
      w_rf_dst    = 1'b0;
      w_data_rf   = 1'b0;
      w_alu_src   = 1'b0;
      w_alu       = ALU_AND;
      w_ill       = 1'b0;
      case (r_state)
         ST_IF: begin
            if (w_timed_out) begin
               w_state_nxt = ST_IF;
            end else begin
               w_req = 1'b1;
               w_ren = 1'b1;
               if (mem.mem_ack) begin
                  w_ir_wen    = 1'b1;
                  w_pc_wen    = 1'b1;
                  w_state_nxt = ST_ID;
               end else begin
                  w_wait_nxt = r_wait_cnt + CNT_W'(1);
               end
            end
         end
         ST_ID: begin
            if (!w_legal) begin
               w_ill       = 1'b1;
               w_state_nxt = ST_IF;
            end else if (w_cls == CLS_J) begin
               w_pc_wen    = 1'b1;
               w_pc_src    = PC_SRC_JMP;
               w_state_nxt = ST_IF;
            end else begin
               w_state_nxt = ST_EX;
            end
         end
         ST_EX: begin
            w_alu     = w_alu_dec;
            w_alu_src = w_imm_op;
            case (w_cls)
               CLS_BEQ: begin
                  w_pc_wen    = alu_zero;
                  w_pc_src    = PC_SRC_BR;
                  w_state_nxt = ST_IF;
               end
               CLS_LW, CLS_SW: w_state_nxt = ST_MEM;
               default:        w_state_nxt = ST_WB;
            endcase
         end
         ST_MEM: begin
            if (w_timed_out) begin
               w_state_nxt = ST_IF;
            end else begin
               w_req  = 1'b1;
               w_iord = 1'b1;
               w_ren  = (w_cls == CLS_LW);
               w_wen  = (w_cls == CLS_SW);
               if (mem.mem_ack) begin
                  w_state_nxt = (w_cls == CLS_SW) ? ST_IF : ST_WB;
               end else begin
                  w_wait_nxt = r_wait_cnt + CNT_W'(1);
               end
            end
         end
         ST_WB: begin
            w_rf_wen    = 1'b1;
            w_rf_dst    = (w_cls == CLS_R);
            w_data_rf   = (w_cls == CLS_LW);
            w_state_nxt = ST_IF;
         end
         default: w_state_nxt = ST_IF;
      endcase
   end

   // Reset forces every control low immediately, independent of the clock
   assign mem.mem_req  = rst & w_req;
   assign mem.mem_ren  = rst & w_ren;
   assign mem.mem_wen  = rst & w_wen;
   assign mem.mem_iord = rst & w_iord;
   assign ir_wen       = rst & w_ir_wen;
   assign pc_wen       = rst & w_pc_wen;
   assign pc_src       = rst ? w_pc_src : 2'b00;
   assign ct_rf_wen    = rst & w_rf_wen;
   assign ct_rf_dst    = rst & w_rf_dst;
   assign ct_data_rf   = rst & w_data_rf;
   assign ct_alu_src   = rst & w_alu_src;
   assign ct_alu       = rst ? w_alu : 4'b0000;
   assign ill_inst     = rst & w_ill;
   assign bus_err      = r_bus_err;

endmodule
